rob_commit_ctrl: RTL
====================

Name: rob_commit_ctrl

Overview:
- Retirement sequencer for the reorder buffer (ROB).
- Watches the ROB head, issues pop strobes when the head entries are no longer pending, and decodes the popped entries into architectural register-file writes.
- Sequences the branch-mispredict flush: stops retirement, pulses the ROB squash input, waits for settle, then resumes.
- Sits between the ROB read side and the register file / rename-release logic.

Parameters:
- DATA_WIDTH, 70: ROB entry width. Fields: [69] pending flag (1 = result not yet written); [68:37] tag; [36:32] destination register; [31:0] value.
- ADDR_WIDTH, 5: ROB depth is 2^ADDR_WIDTH entries.
- COMMIT_WIDTH, 2: maximum retirements per cycle. Legal values 1 or 2.
- FLUSH_WAIT, 2: settle cycles after the squash pulse before retirement resumes. Range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- head_flag0  in  1  pending flag of the ROB head entry
- head_flag1  in  1  pending flag of the head+1 entry
- buf_empty0  in  1  ROB holds 0 entries
- buf_empty1  in  1  ROB holds ≤1 entry
- buf_out0  in  DATA_WIDTH  popped entry 0, valid the cycle after the pop
- buf_out1  in  DATA_WIDTH  popped entry 1, valid the cycle after the pop
- rob_re  out  2  pop count to the ROB: 2'b00 = one, 2'b01 = two
- rob_pop  out  1  single-cycle pop strobe (drives the ROB rclk)
- rob_branch  out  1  single-cycle squash strobe to the ROB
- rob_branch_tag  out  32  tag used with rob_branch (entries with a younger tag are squashed)
- flush_req  in  1  mispredict request, level, sampled on clk
- flush_tag  in  32  tag of the mispredicted branch
- flush_ack  out  1  one-cycle pulse when the flush sequence completes
- rf_stall  in  1  register file cannot accept writes this cycle
- rf_we0, rf_we1  out  1  register-file write enables
- rf_wa0, rf_wa1  out  5  write addresses
- rf_wd0, rf_wd1  out  32  write data
- retire_valid  out  2  per-slot retirement valid, including discarded entries
- retire_tag0, retire_tag1  out  32  tags of the retired entries, for rename release
- busy  out  1  high in any state other than RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0.
  - rob_re = 2'b00, state = RUN, write-back pipeline empty, settle counter 0.
- State RUN, pop decision (combinational from head inputs, registered into rob_pop/rob_re):
  - Pop two (rob_pop = 1, rob_re = 01) when COMMIT_WIDTH = 2, !buf_empty1, !head_flag0, !head_flag1.
  - Otherwise pop one (rob_pop = 1, rob_re = 00) when !buf_empty0 and !head_flag0.
  - Otherwise no pop.
  - No pop is issued in any cycle where rf_stall = 1 or flush_req = 1.
  - Pop strobes may occur on consecutive cycles.
- Write-back stage, one cycle after a pop (pop-to-write latency = 1):
  - Capture buf_out0/1 and drive rf_w*/retire_* for 1 cycle.
  - An entry whose 70 bits are all zero is a squashed slot: retire_valid is set, rf_we = 0, retire_tag = 0.
  - dest = 0: rf_we = 0, retire_valid = 1.
  - Slot 1 is valid only if the pop count was two.
  - If rf_stall rises while a write-back is pending, the write-back outputs hold (rf_we stays asserted) until rf_stall falls. No new pop is issued meanwhile.
- flush_req = 1 in RUN → DRAIN.
  - DRAIN: no pops; wait until the write-back stage is empty (at most 1 cycle, longer if rf_stall holds it). → SQUASH.
  - SQUASH: rob_branch = 1 for exactly 1 cycle, rob_branch_tag = flush_tag latched at DRAIN entry. → SETTLE with counter = FLUSH_WAIT.
  - SETTLE: decrement each cycle; at 0 → RUN with flush_ack pulsed 1 cycle.
  - busy = 1 in DRAIN, SQUASH and SETTLE.
- flush_req held high after flush_ack starts a new sequence from RUN, using the new flush_tag.
- flush_req rising in DRAIN/SQUASH/SETTLE is ignored; the latched tag is used.
- rf_stall and flush_req asserted together: flush wins; DRAIN waits for the stall to clear.
- Empty ROB (buf_empty0): no pop regardless of the flags.
- A head that stays pending blocks both slots: in-order retirement, slot 1 never retires ahead of slot 0.
- Reset mid-flush: the sequence is aborted, all outputs return to 0, no flush_ack is issued.

Optional Feature:
- Macro: ROB_COMMIT_STATS_EN.
- Defined adds three 32-bit saturating counters and read outputs:
  - stat_retired: +1 or +2 per retirement.
  - stat_squashed: retired all-zero entries.
  - stat_stall_cycles: cycles in RUN with ROB non-empty but no pop.
  - All reset to 0 by rst_n; they hold at 32'hFFFFFFFF.
- Undefined: counters and ports are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then ROB with 2 entries, flags 0/0, buf_out0 = {0, tag 5, dest 3, 32'hA5}, buf_out1 = {0, tag 6, dest 0, 32'h1} → one pop with rob_re = 01; next cycle rf_we0 = 1, rf_wa0 = 3, rf_wd0 = 32'hA5, rf_we1 = 0, retire_valid = 2'b11.
- head_flag0 = 1, head_flag1 = 0, 3 entries → no pop for 10 cycles; clear head_flag0 → pop with rob_re = 01 the next cycle.
- COMMIT_WIDTH = 1, 4 ready entries → 4 consecutive pops, all rob_re = 00, 4 write-backs in order.
- Popped entry all zeros → retire_valid[0] = 1, rf_we0 = 0, retire_tag0 = 0.
- flush_req with flush_tag = 32'h12 one cycle after a pop → write-back completes, rob_branch pulses with tag 32'h12, FLUSH_WAIT = 2 idle cycles, flush_ack pulses, busy falls.
- rf_stall held 3 cycles during a pending write-back → rf_we0 stays 1 for 4 cycles, no rob_pop; rst_n low mid-SETTLE → all outputs 0 immediately, no flush_ack.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// rtl/rob_commit_ctrl.sv - ROB retirement sequencer with flush sequencing; optional ROB_COMMIT_STATS_EN counters
module rob_commit_ctrl #(
   parameter int DATA_WIDTH   = 70,
   parameter int ADDR_WIDTH   = 5,
   parameter int COMMIT_WIDTH = 2,
   parameter int FLUSH_WAIT   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  head_flag0,
   input  logic                  head_flag1,
   input  logic                  buf_empty0,
   input  logic                  buf_empty1,
   input  logic [DATA_WIDTH-1:0] buf_out0,
   input  logic [DATA_WIDTH-1:0] buf_out1,
   output logic [1:0]            rob_re,
   output logic                  rob_pop,
   output logic                  rob_branch,
   output logic [31:0]           rob_branch_tag,
   input  logic                  flush_req,
   input  logic [31:0]           flush_tag,
   output logic                  flush_ack,
   input  logic                  rf_stall,
   output logic                  rf_we0,
   output logic                  rf_we1,
   output logic [4:0]            rf_wa0,
   output logic [4:0]            rf_wa1,
   output logic [31:0]           rf_wd0,
   output logic [31:0]           rf_wd1,
   output logic [1:0]            retire_valid,
   output logic [31:0]           retire_tag0,
   output logic [31:0]           retire_tag1,
   output logic                  busy
`ifdef ROB_COMMIT_STATS_EN
   ,
   output logic [31:0]           stat_retired,
   output logic [31:0]           stat_squashed,
   output logic [31:0]           stat_stall_cycles
`endif
);

   if (DATA_WIDTH != 70 || ADDR_WIDTH < 1 || COMMIT_WIDTH < 1 || COMMIT_WIDTH > 2 ||
       FLUSH_WAIT < 1 || FLUSH_WAIT > 15) begin : g_param_check
      $error("rob_commit_ctrl: illegal parameter value");
   end

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_DRAIN  = 2'd1;
   localparam logic [1:0] S_SQUASH = 2'd2;
   localparam logic [1:0] S_SETTLE = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [31:0]           tag_q, tag_d;
   logic                  ack_q, ack_d;
   logic                  rob_pop_q, pop_d, two_d;
   logic [1:0]            rob_re_q;
   logic [1:0]            wb_v_q;
   logic [DATA_WIDTH-1:0] e0_q, e1_q;
   logic                  pp_q, pp_two_q;
   logic                  z0, z1;

   // Pop decision: in-order, only in RUN, never while stalled, flushing or a capture is owed
   always_comb begin
      pop_d = 1'b0;
      two_d = 1'b0;
      if (state_q == S_RUN && !rf_stall && !flush_req && !pp_q) begin
         if (COMMIT_WIDTH == 2 && !buf_empty1 && !head_flag0 && !head_flag1) begin
            pop_d = 1'b1;
            two_d = 1'b1;
         end else if (!buf_empty0 && !head_flag0) begin
            pop_d = 1'b1;
         end
      end
   end

   // Registered pop strobe and count toward the ROB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rob_pop_q <= 1'b0;
         rob_re_q  <= 2'b00;
      end else begin
         rob_pop_q <= pop_d;
         rob_re_q  <= {1'b0, two_d};
      end
   end

   // Write-back capture; a stalled write-back holds, and a pop landing under it is captured once the stall clears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_v_q   <= 2'b00;
         e0_q     <= '0;
         e1_q     <= '0;
         pp_q     <= 1'b0;
         pp_two_q <= 1'b0;
      end else if (wb_v_q != 2'b00 && rf_stall) begin
         if (rob_pop_q) begin
            pp_q     <= 1'b1;
            pp_two_q <= rob_re_q[0];
         end
      end else if (rob_pop_q || pp_q) begin
         e0_q   <= buf_out0;
         e1_q   <= buf_out1;
         wb_v_q <= {(rob_pop_q ? rob_re_q[0] : pp_two_q), 1'b1};
         pp_q   <= 1'b0;
      end else begin
         wb_v_q <= 2'b00;
      end
   end

   // Flush sequencing: drain the write-back, squash once, settle, then resume with an ack
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tag_d   = tag_q;
      ack_d   = 1'b0;
      case (state_q)
         S_RUN: begin
            if (flush_req) begin
               state_d = S_DRAIN;
               tag_d   = flush_tag;
            end
         end
         S_DRAIN: begin
            if (!pp_q && (wb_v_q == 2'b00 || !rf_stall)) state_d = S_SQUASH;
         end
         S_SQUASH: begin
            state_d = S_SETTLE;
            cnt_d   = 4'(FLUSH_WAIT);
         end
         default: begin
            if (cnt_q <= 4'd1) begin
               state_d = S_RUN;
               cnt_d   = 4'd0;
               ack_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
      endcase
   end

   // Flush state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         cnt_q   <= 4'd0;
         tag_q   <= 32'd0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tag_q   <= tag_d;
         ack_q   <= ack_d;
      end
   end

   // Decode of the captured entries; all-zero entries are squashed slots
   always_comb begin
      z0           = (e0_q == '0);
      z1           = (e1_q == '0);
      rf_we0       = wb_v_q[0] && !z0 && (e0_q[36:32] != 5'd0);
      rf_we1       = wb_v_q[1] && !z1 && (e1_q[36:32] != 5'd0);
      rf_wa0       = rf_we0 ? e0_q[36:32] : 5'd0;
      rf_wa1       = rf_we1 ? e1_q[36:32] : 5'd0;
      rf_wd0       = rf_we0 ? e0_q[31:0] : 32'd0;
      rf_wd1       = rf_we1 ? e1_q[31:0] : 32'd0;
      retire_tag0  = wb_v_q[0] ? e0_q[68:37] : 32'd0;
      retire_tag1  = wb_v_q[1] ? e1_q[68:37] : 32'd0;
      retire_valid = wb_v_q;
   end

   assign rob_pop        = rob_pop_q;
   assign rob_re         = rob_re_q;
   assign rob_branch     = (state_q == S_SQUASH);
   assign rob_branch_tag = tag_q;
   assign flush_ack      = ack_q;
   assign busy           = (state_q != S_RUN);

`ifdef ROB_COMMIT_STATS_EN
   logic [31:0] st_ret_q, st_sq_q, st_stall_q;
   logic        wb_fire;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {31'd0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   assign wb_fire = (wb_v_q != 2'b00) && !rf_stall;

   // Saturating statistics, counted when a write-back completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_ret_q   <= 32'd0;
         st_sq_q    <= 32'd0;
         st_stall_q <= 32'd0;
      end else begin
         if (wb_fire) begin
            st_ret_q <= sat_add(st_ret_q, {1'b0, wb_v_q[0]} + {1'b0, wb_v_q[1]});
            st_sq_q  <= sat_add(st_sq_q, {1'b0, wb_v_q[0] & z0} + {1'b0, wb_v_q[1] & z1});
         end
         if (state_q == S_RUN && !buf_empty0 && !pop_d) st_stall_q <= sat_add(st_stall_q, 2'd1);
      end
   end

   assign stat_retired      = st_ret_q;
   assign stat_squashed     = st_sq_q;
   assign stat_stall_cycles = st_stall_q;
`endif

endmodule
